// File: rtl/vscale_htif_tohost_monitor.sv
// Test-completion monitor: round-robin polls the tohost CSR of several vscale cores over
// their HTIF PCR ports and latches a sticky pass / fail / timeout verdict.
module vscale_htif_tohost_monitor #(
    parameter int                    NUM_CHANNELS   = 1,
    parameter int                    DATA_WIDTH     = 64,
    parameter int                    ADDR_WIDTH     = 12,
    parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR    = ADDR_WIDTH'(12'h780),
    parameter logic [DATA_WIDTH-1:0] PASS_VALUE     = DATA_WIDTH'(144),
    parameter int                    TIMEOUT_CYCLES = 2000,
    parameter int                    CNT_WIDTH      = 64
) (
    input  logic                               clk,
    input  logic                               reset,
    output logic [NUM_CHANNELS-1:0]            htif_pcr_req_valid,
    input  logic [NUM_CHANNELS-1:0]            htif_pcr_req_ready,
    output logic [NUM_CHANNELS-1:0]            htif_pcr_req_rw,
    output logic [NUM_CHANNELS*ADDR_WIDTH-1:0] htif_pcr_req_addr,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] htif_pcr_req_data,
    input  logic [NUM_CHANNELS-1:0]            htif_pcr_resp_valid,
    output logic [NUM_CHANNELS-1:0]            htif_pcr_resp_ready,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] htif_pcr_resp_data,
    output logic                               done,
    output logic                               pass,
    output logic                               fail,
    output logic                               timeout,
    output logic [3:0]                         fail_chan,
    output logic [DATA_WIDTH-1:0]              fail_code,
    output logic [NUM_CHANNELS-1:0]            chan_done,
    output logic [CNT_WIDTH-1:0]               cycle_count
);

    localparam int PTR_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] TMO_LAST =
        CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [NUM_CHANNELS-1:0] ALL_DONE = {NUM_CHANNELS{1'b1}};

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_RESP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                    state_r, state_nxt;
    logic [PTR_W-1:0]          ptr_r, ptr_nxt;
    logic [NUM_CHANNELS-1:0]   req_valid_r, req_valid_nxt;
    logic [NUM_CHANNELS-1:0]   resp_ready_r, resp_ready_nxt;
    logic [NUM_CHANNELS-1:0]   chan_done_r, chan_done_nxt;
    logic                      done_r, done_nxt;
    logic                      pass_r, pass_nxt;
    logic                      fail_r, fail_nxt;
    logic                      timeout_r, timeout_nxt;
    logic [3:0]                fail_chan_r, fail_chan_nxt;
    logic [DATA_WIDTH-1:0]     fail_code_r, fail_code_nxt;
    logic [CNT_WIDTH-1:0]      cycle_count_r;

    logic                      req_fire_s;
    logic                      resp_fire_s;
    logic                      tmo_hit_s;
    logic [DATA_WIDTH-1:0]     resp_data_s;

    function automatic logic [NUM_CHANNELS-1:0] onehot_f(input logic [PTR_W-1:0] idx);
        logic [NUM_CHANNELS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Next channel after cur (wrapping) whose pass flag is still clear; cur itself is last resort.
    function automatic logic [PTR_W-1:0] next_ptr_f(input logic [PTR_W-1:0]        cur,
                                                    input logic [NUM_CHANNELS-1:0] cdone);
        logic [PTR_W-1:0] sel;
        logic             found;
        int               idx;
        sel   = cur;
        found = 1'b0;
        for (int k = 1; k <= NUM_CHANNELS; k++) begin
            idx = int'(cur) + k;
            if (idx >= NUM_CHANNELS) begin
                idx = idx - NUM_CHANNELS;
            end else begin
                idx = idx;
            end
            if (!found && !cdone[idx]) begin
                sel   = PTR_W'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return sel;
    endfunction

    assign req_fire_s  = req_valid_r[ptr_r] & htif_pcr_req_ready[ptr_r];
    assign resp_fire_s = resp_ready_r[ptr_r] & htif_pcr_resp_valid[ptr_r];
    assign resp_data_s = htif_pcr_resp_data[ptr_r*DATA_WIDTH +: DATA_WIDTH];
    assign tmo_hit_s   = TMO_EN && (cycle_count_r == TMO_LAST) && !done_r;

    // Poll sequencing and verdict evaluation; a response verdict outranks a same-cycle timeout
    always_comb begin
        state_nxt     = state_r;
        ptr_nxt       = ptr_r;
        chan_done_nxt = chan_done_r;
        done_nxt      = done_r;
        pass_nxt      = pass_r;
        fail_nxt      = fail_r;
        timeout_nxt   = timeout_r;
        fail_chan_nxt = fail_chan_r;
        fail_code_nxt = fail_code_r;
        case (state_r)
            ST_REQ: begin
                if (req_fire_s) begin
                    state_nxt = ST_RESP;
                end else begin
                    state_nxt = ST_REQ;
                end
            end
            ST_RESP: begin
                if (resp_fire_s) begin
                    if (resp_data_s == PASS_VALUE) begin
                        chan_done_nxt[ptr_r] = 1'b1;
                    end else if (resp_data_s != '0) begin
                        fail_nxt      = 1'b1;
                        fail_chan_nxt = 4'(ptr_r);
                        fail_code_nxt = resp_data_s >> 1;
                        done_nxt      = 1'b1;
                    end else begin
                        chan_done_nxt = chan_done_r;
                    end
                    if (fail_nxt) begin
                        state_nxt = ST_DONE;
                    end else if (chan_done_nxt == ALL_DONE) begin
                        pass_nxt  = 1'b1;
                        done_nxt  = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        ptr_nxt   = next_ptr_f(ptr_r, chan_done_nxt);
                        state_nxt = ST_REQ;
                    end
                end else begin
                    state_nxt = ST_RESP;
                end
            end
            ST_DONE: begin
                state_nxt = ST_DONE;
            end
            default: begin
                state_nxt = ST_DONE;
            end
        endcase
        if (tmo_hit_s && !done_nxt) begin
            timeout_nxt = 1'b1;
            done_nxt    = 1'b1;
            state_nxt   = ST_DONE;
        end else begin
            timeout_nxt = timeout_nxt;
        end
        req_valid_nxt  = (state_nxt == ST_REQ)  ? onehot_f(ptr_nxt) : '0;
        resp_ready_nxt = (state_nxt == ST_RESP) ? onehot_f(ptr_nxt) : '0;
    end

    // FSM, handshake outputs and sticky result registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_REQ;
            ptr_r        <= '0;
            req_valid_r  <= '0;
            resp_ready_r <= '0;
            chan_done_r  <= '0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            fail_r       <= 1'b0;
            timeout_r    <= 1'b0;
            fail_chan_r  <= 4'd0;
            fail_code_r  <= '0;
        end else begin
            state_r      <= state_nxt;
            ptr_r        <= ptr_nxt;
            req_valid_r  <= req_valid_nxt;
            resp_ready_r <= resp_ready_nxt;
            chan_done_r  <= chan_done_nxt;
            done_r       <= done_nxt;
            pass_r       <= pass_nxt;
            fail_r       <= fail_nxt;
            timeout_r    <= timeout_nxt;
            fail_chan_r  <= fail_chan_nxt;
            fail_code_r  <= fail_code_nxt;
        end
    end

    // Saturating cycle counter, frozen once a verdict is reached
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_count_r <= '0;
        end else if (!done_r && (cycle_count_r != '1)) begin
            cycle_count_r <= cycle_count_r + CNT_WIDTH'(1);
        end else begin
            cycle_count_r <= cycle_count_r;
        end
    end

    assign htif_pcr_req_valid  = req_valid_r;
    assign htif_pcr_resp_ready = resp_ready_r;
    assign htif_pcr_req_rw     = '0;
    assign htif_pcr_req_addr   = {NUM_CHANNELS{TOHOST_ADDR}};
    assign htif_pcr_req_data   = '0;
    assign done                = done_r;
    assign pass                = pass_r;
    assign fail                = fail_r;
    assign timeout             = timeout_r;
    assign fail_chan           = fail_chan_r;
    assign fail_code           = fail_code_r;
    assign chan_done           = chan_done_r;
    assign cycle_count         = cycle_count_r;

endmodule

// File: doc/vscale_htif_tohost_monitor.md
Name: vscale_htif_tohost_monitor

Overview:
- Synthesizable, parametrised test-completion monitor for multi-core vscale configurations.
- Round-robin polls the tohost CSR of NUM_CHANNELS cores over their HTIF PCR ports. Decides pass, fail or timeout, and holds a sticky verdict.
- Instantiated beside vscale_top instances, in simulation harnesses and FPGA builds.
- Adds over the existing single-core bench check: multi-channel polling, a real req/resp handshake, configurable pass value, per-channel completion tracking and fail attribution.

Parameters:
- NUM_CHANNELS, 1, number of cores monitored (1..16)
- DATA_WIDTH, 64, HTIF PCR data width
- ADDR_WIDTH, 12, HTIF PCR address width
- TOHOST_ADDR, 12'h780, CSR address read on every poll
- PASS_VALUE, 144, tohost value that marks a channel passed
- TIMEOUT_CYCLES, 2000, cycle budget; 0 disables timeout
- CNT_WIDTH, 64, cycle counter width

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- htif_pcr_req_valid  output  NUM_CHANNELS  per-channel request valid
- htif_pcr_req_ready  input  NUM_CHANNELS  per-channel request ready
- htif_pcr_req_rw  output  NUM_CHANNELS  always 0 (read)
- htif_pcr_req_addr  output  NUM_CHANNELS*ADDR_WIDTH  packed, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- htif_pcr_req_data  output  NUM_CHANNELS*DATA_WIDTH  always 0
- htif_pcr_resp_valid  input  NUM_CHANNELS  per-channel response valid
- htif_pcr_resp_ready  output  NUM_CHANNELS  per-channel response ready
- htif_pcr_resp_data  input  NUM_CHANNELS*DATA_WIDTH  packed response data
- done  output  1  verdict reached (sticky)
- pass  output  1  all channels returned PASS_VALUE
- fail  output  1  some channel returned a non-zero, non-pass value
- timeout  output  1  cycle budget exhausted before verdict
- fail_chan  output  4  channel index of first failure
- fail_code  output  DATA_WIDTH  failing tohost value >> 1
- chan_done  output  NUM_CHANNELS  per-channel pass flags
- cycle_count  output  CNT_WIDTH  cycles since reset release

Behaviour:
- Reset (reset==0 at posedge):
  - All outputs and registers become 0; FSM enters REQ; poll pointer = 0.
  - All req_valid/resp_ready drop in the same cycle. Any outstanding transaction is abandoned; the cores are reset alongside.
- Address and data outputs:
  - req_addr = TOHOST_ADDR on all channels, constant.
  - req_rw = 0 and req_data = 0, constant.
- FSM states:
  - REQ:
    - req_valid[ptr]=1; addr stable.
    - On req_ready[ptr] -> RESP.
    - req_valid must not drop before acceptance.
  - RESP:
    - resp_ready[ptr]=1, all other resp_ready=0.
    - On resp_valid[ptr] -> evaluate data in the handshake cycle. Result registers update at the next posedge; the FSM moves to REQ for the next channel, or to DONE.
  - DONE: all valid/ready low; outputs frozen until reset.
- Only one transaction is outstanding at a time; responses on non-polled channels are ignored (their resp_ready stays 0).
- Evaluation of data D on channel ptr:
  - D==0: no change.
  - D==PASS_VALUE: chan_done[ptr]<=1.
  - Otherwise: fail<=1, fail_chan<=ptr, fail_code<=D>>1, done<=1.
  - If chan_done becomes all-ones: pass<=1, done<=1.
- Pointer advance: next index (mod NUM_CHANNELS) whose chan_done bit is clear; passed channels are skipped.
- Cycle counter:
  - Increments every cycle while done==0, starting from 0 after reset release. Saturates at all-ones.
  - Timeout: TIMEOUT_CYCLES!=0 and cycle_count==TIMEOUT_CYCLES-1 while not done -> next posedge timeout<=1, done<=1, FSM -> DONE.
- Simultaneous events: a response evaluated in the same cycle as the timeout condition takes priority. Pass/fail is recorded and timeout stays 0.
- Exclusivity: at most one of pass, fail, timeout is ever 1.
- NUM_CHANNELS==1: pointer stays 0.

Test Plan:
- Single channel, req_ready=1, resp one cycle later with D=0 three times, then D=144 -> pass=1, done=1, chan_done=1. req_valid toggles once per poll; timeout=0.
- NUM_CHANNELS=4: ch2 returns 144 first, later polls skip ch2 (req_valid[2] never reasserted); others then return 144 -> pass=1, chan_done=4'hF.
- NUM_CHANNELS=2: ch1 returns D=7 -> fail=1, fail_chan=1, fail_code=3, done=1. All req_valid/resp_ready are 0 afterwards; cycle_count frozen.
- TIMEOUT_CYCLES=50, responses always D=0 -> timeout=1 and cycle_count=50 at done. The same cycle a D=144 response completes the set yields pass=1, timeout=0.
- req_ready held low 10 cycles -> req_valid and req_addr=12'h780 stable throughout; resp_ready stays 0 until acceptance.
- reset driven low while in RESP -> next cycle all outputs 0, req_valid[0]=1 after release, cycle_count restarts at 0.
